// File: rtl/terminal_writer.sv
// Writer side of the display RAM. It turns an ASCII stream into RAM writes, tracks the cursor,
// and scrolls by rotating top_row rather than copying rows.
module terminal_writer #(
  parameter int         COLS  = 40,
  parameter int         ROWS  = 24,
  parameter logic [5:0] BLANK = 6'h20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        char_valid,
  input  logic [6:0]  char_in,
  output logic        char_ready,
  input  logic        clr_screen,
  output logic [10:0] write_addr,
  output logic        w_en,
  output logic [5:0]  dout,
  output logic [5:0]  cursor_x,
  output logic [4:0]  cursor_y,
  output logic [4:0]  top_row,
  output logic        busy
);

  localparam logic [1:0] S_IDLE       = 2'd0;
  localparam logic [1:0] S_WRITE      = 2'd1;
  localparam logic [1:0] S_CLEAR_LINE = 2'd2;
  localparam logic [1:0] S_CLEAR_ALL  = 2'd3;

  localparam logic [5:0]  LAST_COL  = 6'(COLS - 1);
  localparam logic [4:0]  LAST_ROW  = 5'(ROWS - 1);
  localparam logic [10:0] LAST_ADDR = 11'(COLS * ROWS - 1);

  logic [1:0]  state_q, state_d;
  logic [5:0]  col_q, col_d;
  logic [4:0]  row_q, row_d;
  logic [4:0]  top_q, top_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        pend_q, pend_d;
  logic [10:0] addr_q, addr_d;
  logic        w_en_q, w_en_d;
  logic [5:0]  dout_q, dout_d;
  logic        ready_q, ready_d;
  logic        busy_q, busy_d;

  logic       accept, is_cr, is_print, newline, start_clear;
  logic [5:0] code;

  // First RAM address of the logical row, after rotating by top_row.
  function automatic logic [10:0] row_base(input logic [4:0] top, input logic [4:0] row);
    logic [5:0] sum;
    sum = {1'b0, top} + {1'b0, row};
    if (sum >= 6'(ROWS)) sum = sum - 6'(ROWS);
    return 11'(sum) * 11'(COLS);
  endfunction

  // A clear request in the same cycle withdraws the offer, so a char is never lost to a clear.
  assign char_ready = ready_q & ~clr_screen;
  assign accept     = char_valid & char_ready;
  assign is_cr      = (char_in == 7'h0D);
  assign is_print   = (char_in >= 7'h20) && (char_in <= 7'h7E);
  // Lowercase folding drops bit 5; on the 0x20..0x5F range the low six bits pass through.
  assign code       = {char_in[5] & ~char_in[6], char_in[4:0]};

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    top_d       = top_q;
    cnt_d       = cnt_q;
    pend_d      = pend_q;
    addr_d      = addr_q;
    dout_d      = dout_q;
    w_en_d      = 1'b0;
    newline     = 1'b0;
    start_clear = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (clr_screen || pend_q) begin
          start_clear = 1'b1;
        end else if (accept) begin
          if (is_print) begin
            state_d = S_WRITE;
            w_en_d  = 1'b1;
            addr_d  = row_base(top_q, row_q) + 11'(col_q);
            dout_d  = code;
          end else if (is_cr) begin
            newline = 1'b1;
          end
        end
      end
      S_WRITE: begin
        state_d = S_IDLE;
        if (col_q == LAST_COL) newline = 1'b1;
        else                   col_d   = col_q + 6'd1;
      end
      S_CLEAR_LINE: begin
        if (cnt_q == LAST_COL) begin
          state_d = S_IDLE;
        end else begin
          cnt_d  = cnt_q + 6'd1;
          w_en_d = 1'b1;
          addr_d = addr_q + 11'd1;
          dout_d = BLANK;
        end
      end
      default: begin
        if (clr_screen) begin
          start_clear = 1'b1;
        end else if (!w_en_q) begin
          // First cycle after reset: nothing written yet, begin at address 0.
          w_en_d = 1'b1;
          addr_d = 11'd0;
          dout_d = BLANK;
        end else if (addr_q == LAST_ADDR) begin
          state_d = S_IDLE;
        end else begin
          w_en_d = 1'b1;
          addr_d = addr_q + 11'd1;
          dout_d = BLANK;
        end
      end
    endcase

    if (newline) begin
      col_d = 6'd0;
      if (row_q != LAST_ROW) begin
        row_d = row_q + 5'd1;
      end else begin
        top_d   = (top_q == LAST_ROW) ? 5'd0 : top_q + 5'd1;
        state_d = S_CLEAR_LINE;
        cnt_d   = 6'd0;
        w_en_d  = 1'b1;
        addr_d  = row_base(top_d, LAST_ROW);
        dout_d  = BLANK;
      end
    end

    if (clr_screen && (state_q == S_WRITE || state_q == S_CLEAR_LINE)) pend_d = 1'b1;

    if (start_clear) begin
      state_d = S_CLEAR_ALL;
      pend_d  = 1'b0;
      top_d   = 5'd0;
      col_d   = 6'd0;
      row_d   = 5'd0;
      w_en_d  = 1'b1;
      addr_d  = 11'd0;
      dout_d  = BLANK;
    end

    ready_d = (state_d == S_IDLE) && !pend_d;
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q <= S_CLEAR_ALL;
      col_q   <= 6'd0;
      row_q   <= 5'd0;
      top_q   <= 5'd0;
      cnt_q   <= 6'd0;
      pend_q  <= 1'b0;
      addr_q  <= 11'd0;
      w_en_q  <= 1'b0;
      dout_q  <= BLANK;
      ready_q <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      top_q   <= top_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      addr_q  <= addr_d;
      w_en_q  <= w_en_d;
      dout_q  <= dout_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign write_addr = addr_q;
  assign w_en       = w_en_q;
  assign dout       = dout_q;
  assign cursor_x   = col_q;
  assign cursor_y   = row_q;
  assign top_row    = top_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_terminal_writer.sv
// Directed bench for terminal_writer at 40x24: clears, character writes, wrap, scroll,
// clear priority over a pending character, and reset during a line clear.
module tb_terminal_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic        char_valid;
  logic [6:0]  char_in;
  logic        char_ready;
  logic        clr_screen;
  logic [10:0] write_addr;
  logic        w_en;
  logic [5:0]  dout;
  logic [5:0]  cursor_x;
  logic [4:0]  cursor_y;
  logic [4:0]  top_row;
  logic        busy;

  int vectors     = 0;
  int miscompares = 0;

  logic        obs_wen;
  logic [10:0] obs_addr;
  logic [5:0]  obs_dout;

  terminal_writer #(.COLS(40), .ROWS(24), .BLANK(6'h20)) dut (
    .clk        (clk),
    .reset      (reset),
    .char_valid (char_valid),
    .char_in    (char_in),
    .char_ready (char_ready),
    .clr_screen (clr_screen),
    .write_addr (write_addr),
    .w_en       (w_en),
    .dout       (dout),
    .cursor_x   (cursor_x),
    .cursor_y   (cursor_y),
    .top_row    (top_row),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Called at a negedge; returns at the negedge after the handshake edge with that cycle's write port.
  task automatic send(input logic [6:0] c);
    int n = 0;
    char_in    = c;
    char_valid = 1'b1;
    #1;
    while (!char_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", n < 50, 1);
    @(posedge clk);
    @(negedge clk);
    obs_wen    = w_en;
    obs_addr   = write_addr;
    obs_dout   = dout;
    char_valid = 1'b0;
  endtask

  // Follows a run of blank writes; returns at the first negedge with w_en low.
  task automatic expect_clear(input string tag, input int start, input int n);
    int waitc = 0;
    int len   = 0;
    int errs  = 0;
    while (!w_en && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    while (w_en && len < 2000) begin
      if (write_addr !== 11'(start + len) || dout !== 6'h20) errs++;
      len++;
      @(negedge clk);
    end
    check({tag, "_addr_data"}, errs, 0);
    check({tag, "_len"}, len, n);
  endtask

  initial begin
    int errs;
    reset      = 1'b1;
    char_valid = 1'b0;
    char_in    = 7'h00;
    clr_screen = 1'b0;

    // 1: reset values, then the power-on clear
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_wen", w_en, 0);
    check("rst_addr", write_addr, 0);
    check("rst_dout", dout, 6'h20);
    check("rst_cursor", {cursor_x, cursor_y}, 0);
    check("rst_top", top_row, 0);
    check("rst_ready", char_ready, 0);
    check("rst_busy", busy, 1);
    reset = 1'b0;
    expect_clear("boot", 0, 960);
    check("boot_ready", char_ready, 1);
    check("boot_busy", busy, 0);
    check("boot_cursor", {cursor_x, cursor_y}, 0);

    // 2: uppercase, folded lowercase, ignored control char
    send(7'h41);
    check("A_write", {obs_wen, obs_addr, obs_dout}, {1'b1, 11'd0, 6'h01});
    check("A_busy", busy, 1);
    @(negedge clk);
    check("A_ready_again", char_ready, 1);
    send(7'h61);
    check("a_write", {obs_wen, obs_addr, obs_dout}, {1'b1, 11'd1, 6'h01});
    @(negedge clk);
    send(7'h07);
    check("bel_no_write", obs_wen, 0);
    check("bel_cursor_x", cursor_x, 2);

    // 3: clear, then fill row 0 and wrap without a line clear
    clr_screen = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clr_screen = 1'b0;
    expect_clear("clr1", 0, 960);
    errs = 0;
    for (int i = 0; i < 40; i++) begin
      send(7'(7'h30 + i));
      if (!obs_wen || obs_addr !== 11'(i) || obs_dout !== 6'(6'h30 + i)) errs++;
    end
    check("row0_writes", errs, 0);
    check("row0_last_addr", obs_addr, 39);
    @(negedge clk);
    check("wrap_cursor", {cursor_x, cursor_y}, {6'd0, 5'd1});
    check("wrap_no_clear", {w_en, char_ready}, 2'b01);
    send(7'h0D);
    check("cr_no_write", obs_wen, 0);
    check("cr_cursor", {cursor_x, cursor_y}, {6'd0, 5'd2});

    // 4: scroll from (5,23)
    errs = 0;
    for (int i = 0; i < 21; i++) begin
      send(7'h0D);
      if (obs_wen) errs++;
    end
    check("cr_run_no_write", errs, 0);
    check("row23", cursor_y, 23);
    errs = 0;
    for (int i = 0; i < 5; i++) begin
      send(7'h58);
      if (!obs_wen || obs_addr !== 11'(920 + i) || obs_dout !== 6'h18) errs++;
    end
    check("row23_writes", errs, 0);
    @(negedge clk);
    check("pre_scroll_cursor", {cursor_x, cursor_y}, {6'd5, 5'd23});
    send(7'h0D);
    check("scroll_first", {obs_wen, obs_addr, obs_dout}, {1'b1, 11'd0, 6'h20});
    check("scroll_top", top_row, 1);
    check("scroll_cursor", {cursor_x, cursor_y}, {6'd0, 5'd23});
    expect_clear("line", 0, 40);
    check("line_done", {char_ready, busy}, 2'b10);
    send(7'h42);
    check("B_write", {obs_wen, obs_addr, obs_dout}, {1'b1, 11'd0, 6'h02});

    // 5: clear beats a simultaneously offered char
    @(negedge clk);
    char_in    = 7'h43;
    char_valid = 1'b1;
    clr_screen = 1'b1;
    #1;
    check("clr_blocks_ready", char_ready, 0);
    @(posedge clk);
    @(negedge clk);
    clr_screen = 1'b0;
    check("clr_first", {w_en, write_addr, dout}, {1'b1, 11'd0, 6'h20});
    expect_clear("clr2", 0, 960);
    check("clr2_top", top_row, 0);
    check("clr2_cursor", {cursor_x, cursor_y}, 0);
    check("clr2_ready", char_ready, 1);
    @(posedge clk);
    @(negedge clk);
    char_valid = 1'b0;
    check("C_write", {w_en, write_addr, dout}, {1'b1, 11'd0, 6'h03});

    // 6: reset in the middle of a line clear
    @(negedge clk);
    for (int i = 0; i < 23; i++) send(7'h0D);
    @(negedge clk);
    check("pre_reset_cursor", {cursor_x, cursor_y}, {6'd0, 5'd23});
    send(7'h0D);
    check("line2_first", {obs_wen, obs_addr}, {1'b1, 11'd0});
    repeat (10) @(negedge clk);
    check("line2_mid", {w_en, write_addr}, {1'b1, 11'd10});
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_wen", w_en, 0);
    check("abort_state", {cursor_x, cursor_y, top_row}, 0);
    check("abort_busy", {busy, char_ready}, 2'b10);
    reset = 1'b0;
    expect_clear("reclr", 0, 960);
    check("final_idle", {busy, char_ready}, 2'b01);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
